// File: rtl/pipeline_reg_pkg.sv
// pipeline_reg_pkg: writeback entry type and default field widths shared by the lane writeback arbiter.
package pipeline_reg_pkg;
    localparam int WB_DATA_W   = 18;
    localparam int WB_THREAD_W = 4;
    localparam int WB_RD_W     = 4;

    typedef struct packed {
        logic                   regwrite;
        logic                   set_pred;
        logic                   new_pred_val;
        logic [WB_THREAD_W-1:0] thread_num;
        logic [WB_RD_W-1:0]     rd;
        logic [WB_DATA_W-1:0]   write_data;
    } wb_entry_t;

    // Flattened entry layout: {regwrite, set_pred, new_pred_val, thread, rd, data}
    function automatic int entry_width(input int data_w, input int thread_w, input int rd_w);
        return 3 + thread_w + rd_w + data_w;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  rd_ptr, wr_ptr;
    logic         do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/lane_wb_arbiter.sv
// lane_wb_arbiter: per-lane register-file writeback arbiter; channel 0 has absolute priority, others are
// FIFO-buffered and drained round-robin. Define WB_ARB_STATS_EN to add conflict_cnt/max_occ statistics.
module lane_wb_arbiter
    import pipeline_reg_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2,
    parameter int DATA_W       = WB_DATA_W,
    parameter int THREAD_W     = WB_THREAD_W,
    parameter int RD_W         = WB_RD_W
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_regwrite,
    input  logic [NUM_CH-1:0]          in_set_pred,
    input  logic [NUM_CH-1:0]          in_pred_val,
    input  logic [NUM_CH*THREAD_W-1:0] in_thread,
    input  logic [NUM_CH*RD_W-1:0]     in_rd,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       wb_regwrite,
    output logic                       wb_set_pred,
    output logic                       wb_pred_val,
    output logic [THREAD_W-1:0]        wb_thread,
    output logic [RD_W-1:0]            wb_rd,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(NUM_CH)-1:0]  wb_src,
    output logic                       stall_req,
    output logic                       overflow
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]                conflict_cnt,
    output logic [$clog2(FIFO_DEPTH):0] max_occ
`endif
);
    localparam int SRC_W = $clog2(NUM_CH);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = entry_width(DATA_W, THREAD_W, RD_W);
    localparam int THR   = FIFO_DEPTH - STALL_MARGIN;

    logic [EW-1:0]     in_entry [NUM_CH];
    logic [NUM_CH-1:0] in_valid;
    logic [EW-1:0]     head [1:NUM_CH-1];
    logic [EW-1:0]     cand [1:NUM_CH-1];
    logic [CW-1:0]     count [1:NUM_CH-1];
    logic [CW-1:0]     cnt_nxt [1:NUM_CH-1];
    logic [NUM_CH-1:1] cand_vld, bgnt, push, pop, full, empty, drop;
    logic [SRC_W-1:0]  gnt, rr_ptr;
    logic [EW-1:0]     sel;
    logic              gnt_vld, stall_nxt;
    int                idx;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_in
        assign in_entry[k] = {in_regwrite[k], in_set_pred[k], in_pred_val[k],
                              in_thread[k*THREAD_W +: THREAD_W], in_rd[k*RD_W +: RD_W],
                              in_data[k*DATA_W +: DATA_W]};
        assign in_valid[k] = in_regwrite[k] | in_set_pred[k];
    end

    // Buffered channel: FIFO head takes precedence over the incoming entry to keep per-channel order
    for (genvar k = 1; k < NUM_CH; k++) begin : g_ch
        assign cand_vld[k] = !empty[k] || in_valid[k];
        assign cand[k]     = empty[k] ? in_entry[k] : head[k];
        assign bgnt[k]     = !in_valid[0] && gnt_vld && gnt == SRC_W'(k);
        assign pop[k]      = bgnt[k] && !empty[k];
        assign push[k]     = in_valid[k] && !(bgnt[k] && empty[k]);
        assign drop[k]     = push[k] && full[k] && !pop[k];
        assign cnt_nxt[k]  = count[k] + CW'(push[k] && !drop[k]) - CW'(pop[k]);
        wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_entry[k]),
            .head  (head[k]),
            .count (count[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    always_comb begin
        gnt_vld = in_valid[0];
        gnt     = '0;
        sel     = in_entry[0];
        idx     = 0;
        for (int i = 0; i < NUM_CH - 1; i++) begin
            idx = (int'(rr_ptr) - 1 + i) % (NUM_CH - 1) + 1;
            if (!gnt_vld && cand_vld[idx]) begin
                gnt_vld = 1'b1;
                gnt     = SRC_W'(idx);
                sel     = cand[idx];
            end
        end
    end

    always_comb begin
        stall_nxt = 1'b0;
        for (int k = 1; k < NUM_CH; k++)
            if (int'(cnt_nxt[k]) >= THR) stall_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wb_regwrite <= 1'b0;
            wb_set_pred <= 1'b0;
            wb_pred_val <= 1'b0;
            wb_thread   <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_src      <= '0;
            rr_ptr      <= SRC_W'(1);
            stall_req   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wb_regwrite <= gnt_vld && sel[EW-1];
            wb_set_pred <= gnt_vld && sel[EW-2];
            if (gnt_vld) begin
                wb_pred_val <= sel[EW-3];
                wb_thread   <= sel[DATA_W+RD_W +: THREAD_W];
                wb_rd       <= sel[DATA_W +: RD_W];
                wb_data     <= sel[DATA_W-1:0];
                wb_src      <= gnt;
            end
            if (gnt_vld && !in_valid[0])
                rr_ptr <= (int'(gnt) == NUM_CH - 1) ? SRC_W'(1) : gnt + SRC_W'(1);
            stall_req <= stall_nxt;
            overflow  <= overflow || |drop;
        end

`ifdef WB_ARB_STATS_EN
    logic          conflict;
    logic [CW-1:0] occ_nxt;

    always_comb begin
        conflict = |(cand_vld & ~bgnt);
        occ_nxt  = max_occ;
        for (int k = 1; k < NUM_CH; k++)
            if (cnt_nxt[k] > occ_nxt) occ_nxt = cnt_nxt[k];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            conflict_cnt <= '0;
            max_occ      <= '0;
        end else begin
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            max_occ <= occ_nxt;
        end
`endif
endmodule

// File: tb/tb_lane_wb_arbiter.sv
// tb_lane_wb_arbiter: directed and randomized bench for lane_wb_arbiter (NUM_CH=3) against a queue-based model.
module tb_lane_wb_arbiter;
    typedef struct packed {
        logic        rw;
        logic        sp;
        logic        pv;
        logic [3:0]  th;
        logic [3:0]  rd;
        logic [17:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_regwrite, in_set_pred, in_pred_val;
    logic [11:0] in_thread, in_rd;
    logic [53:0] in_data;
    logic        wb_regwrite, wb_set_pred, wb_pred_val, stall_req, overflow;
    logic [3:0]  wb_thread, wb_rd;
    logic [17:0] wb_data;
    logic [1:0]  wb_src;
`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [2:0]  max_occ;
`endif

    always #5 clk = ~clk;

    lane_wb_arbiter #(.NUM_CH(3), .FIFO_DEPTH(4), .STALL_MARGIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_regwrite (in_regwrite),
        .in_set_pred (in_set_pred),
        .in_pred_val (in_pred_val),
        .in_thread   (in_thread),
        .in_rd       (in_rd),
        .in_data     (in_data),
        .wb_regwrite (wb_regwrite),
        .wb_set_pred (wb_set_pred),
        .wb_pred_val (wb_pred_val),
        .wb_thread   (wb_thread),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_src      (wb_src),
        .stall_req   (stall_req),
        .overflow    (overflow)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .max_occ     (max_occ)
`endif
    );

    int   errors = 0;
    int   checks = 0;
    ent_t q [3][$];
    ent_t cur [3];
    ent_t exp_e;
    logic [1:0] exp_src;
    logic exp_stall, exp_ov;
    int   rr;
    ent_t z = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input ent_t e);
        return e.rw | e.sp;
    endfunction

    function automatic ent_t mk(input logic rw, input logic sp, input logic pv,
                                input logic [3:0] th, input logic [3:0] rd, input logic [17:0] d);
        ent_t e;
        e.rw = rw; e.sp = sp; e.pv = pv; e.th = th; e.rd = rd; e.data = d;
        return e;
    endfunction

    function automatic ent_t rnd(input int pct);
        ent_t e;
        e.pv   = 1'($urandom);
        e.th   = 4'($urandom);
        e.rd   = 4'($urandom);
        e.data = 18'($urandom);
        {e.rw, e.sp} = ($urandom_range(99) < pct) ? 2'($urandom_range(3, 1)) : 2'b00;
        return e;
    endfunction

    // One arbitration step of the reference: priority, round-robin, per-channel queues
    task automatic model();
        int   g = -1;
        ent_t o = '0;
        if (vld(cur[0])) begin
            g = 0;
            o = cur[0];
        end else
            for (int i = 0; i < 2; i++) begin
                int k;
                k = (rr - 1 + i) % 2 + 1;
                if (g < 0 && (q[k].size() > 0 || vld(cur[k]))) begin
                    g = k;
                    o = q[k].size() > 0 ? q[k][0] : cur[k];
                end
            end
        for (int k = 1; k < 3; k++) begin
            if (g == k && q[k].size() > 0) begin
                void'(q[k].pop_front());
                if (vld(cur[k])) q[k].push_back(cur[k]);
            end else if (g != k && vld(cur[k])) begin
                if (q[k].size() == 4) exp_ov = 1'b1;
                else q[k].push_back(cur[k]);
            end
        end
        if (g > 0) rr = (g == 2) ? 1 : g + 1;
        if (g >= 0) begin
            exp_e   = o;
            exp_src = 2'(g);
        end else begin
            exp_e.rw = 1'b0;
            exp_e.sp = 1'b0;
        end
        exp_stall = q[1].size() >= 2 || q[2].size() >= 2;
    endtask

    task automatic apply();
        in_regwrite = {cur[2].rw, cur[1].rw, cur[0].rw};
        in_set_pred = {cur[2].sp, cur[1].sp, cur[0].sp};
        in_pred_val = {cur[2].pv, cur[1].pv, cur[0].pv};
        in_thread   = {cur[2].th, cur[1].th, cur[0].th};
        in_rd       = {cur[2].rd, cur[1].rd, cur[0].rd};
        in_data     = {cur[2].data, cur[1].data, cur[0].data};
    endtask

    task automatic cyc(input ent_t a, input ent_t b, input ent_t c);
        @(negedge clk);
        cur[0] = a; cur[1] = b; cur[2] = c;
        apply();
        model();
        @(posedge clk);
        #1;
        check("wb", {wb_regwrite, wb_set_pred, wb_pred_val, wb_thread, wb_rd, wb_data, wb_src}, {exp_e, exp_src});
        check("stall", stall_req, exp_stall);
        check("ovf", overflow, exp_ov);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cur[0] = z; cur[1] = z; cur[2] = z;
        apply();
        q[1].delete();
        q[2].delete();
        rr = 1; exp_e = '0; exp_src = '0; exp_stall = 1'b0; exp_ov = 1'b0;
        #1;
        check("rst_wb", {wb_regwrite, wb_set_pred, wb_pred_val, wb_thread, wb_rd, wb_data, wb_src}, 0);
        check("rst_flags", {stall_req, overflow}, 0);
`ifdef WB_ARB_STATS_EN
        check("rst_stats", {conflict_cnt, max_occ}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  src_seq [6];
        logic [17:0] dat_seq [6];
        src_seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        dat_seq = '{18'h100, 18'h200, 18'h101, 18'h201, 18'h102, 18'h202};
        cur[0] = z; cur[1] = z; cur[2] = z;
        apply();
        do_reset();

        // Channel 0 alone
        cyc(mk(1, 0, 0, 4'd3, 4'd5, 18'h1234), z, z);
        check("t1_wb", {wb_regwrite, wb_rd, wb_data, wb_src}, {1'b1, 4'd5, 18'h1234, 2'd0});

        // Channel 0 wins, channel 1 follows from its FIFO
        do_reset();
        cyc(mk(1, 0, 0, 4'd1, 4'd1, 18'h0111), mk(1, 0, 0, 4'd2, 4'd2, 18'h0AAA), z);
        check("t2_first", {wb_src, wb_data}, {2'd0, 18'h0111});
        cyc(z, z, z);
        check("t2_second", {wb_regwrite, wb_src, wb_data}, {1'b1, 2'd1, 18'h0AAA});
        check("t2_ovf", overflow, 1'b0);

        // Round-robin between channels 1 and 2
        do_reset();
        for (int n = 0; n < 6; n++) begin
            if (n < 3) cyc(z, mk(1, 0, 0, 4'd1, 4'(n), 18'h100 + 18'(n)), mk(1, 0, 0, 4'd2, 4'(n), 18'h200 + 18'(n)));
            else cyc(z, z, z);
            check("t3_order", {wb_src, wb_data}, {src_seq[n], dat_seq[n]});
        end

        // Backpressure and overflow
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            cyc(mk(1, 0, 0, 4'd0, 4'(n), 18'h3000 + 18'(n)), mk(1, 0, 0, 4'd1, 4'(n), 18'h1000 + 18'(n)), z);
            check("t4_stall", stall_req, n >= 2);
            check("t4_ovf", overflow, n >= 5);
        end
        for (int n = 0; n < 6; n++) cyc(z, z, z);
        check("t4_stall_drained", stall_req, 1'b0);

        // Predicate-only write
        do_reset();
        cyc(z, mk(0, 1, 1, 4'd2, 4'd3, 18'h5), z);
        check("t5_pred", {wb_set_pred, wb_regwrite, wb_pred_val, wb_src}, {1'b1, 1'b0, 1'b1, 2'd1});

        // Reset with queued entries
        do_reset();
        for (int n = 0; n < 3; n++)
            cyc(mk(1, 0, 0, 4'd0, 4'd0, 18'h7), mk(1, 0, 0, 4'd1, 4'(n), 18'h2A0 + 18'(n)), z);
        do_reset();
        for (int n = 0; n < 3; n++) begin
            cyc(z, z, z);
            check("t6_no_stale", {wb_regwrite, wb_set_pred}, 2'b00);
        end

        // Randomized traffic with occasional resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int n = 0; n < 150; n++) cyc(rnd(30), rnd(40), rnd(40));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
